// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: FSM state encoding, wait-counter width and the word returned on a
//          faulted fetch. Imported by instr_mem_fetch_unit.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - DEPTH x DATA_W program storage, 1 sync write + 1 sync read port
//
// Purpose: program storage with no reset. A read and a write to the same word
//          on the same edge return the old contents (read-before-write).
// Ports:
//   clk_i      in   clock
//   wr_en_i    in   write enable
//   wr_addr_i  in   word index to write
//   wr_data_i  in   word to write
//   rd_en_i    in   read enable; rd_data_o only changes when this is high
//   rd_addr_i  in   word index to read
//   rd_data_o  out  registered read data, held between reads
module instr_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Both accesses use non-blocking updates, so a same-edge collision reads
  // the value that was stored before this edge.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch_unit.sv
// rtl/instr_mem_fetch_unit.sv - word-addressed instruction memory with req/valid fetch handshake
//
// Purpose: accepts byte-addressed fetch requests, waits WAIT_CYC cycles, then
//          returns the word (or NOP on a misaligned / out-of-range address)
//          with a one-cycle valid pulse. A separate load port writes programs.
// Ports:
//   clk_i          in   clock
//   rst_i          in   synchronous reset, active low
//   fetch_req_i    in   fetch request, held until accepted
//   fetch_addr_i   in   byte address to fetch
//   fetch_ready_o  out  a request is accepted this cycle if fetch_req_i is high
//   fetch_valid_o  out  one-cycle pulse: instr_o and fault flags are valid
//   instr_o        out  fetched word, held until the next response
//   misalign_o     out  response address had nonzero low two bits
//   range_err_o    out  response word index was >= DEPTH
//   load_en_i      in   program-load write enable (ignored during reset)
//   load_addr_i    in   word index to write
//   load_data_i    in   word to write
module instr_mem_fetch_unit
  import instr_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_req_i,
  input  logic [ADDR_W-1:0]        fetch_addr_i,
  output logic                     fetch_ready_o,
  output logic                     fetch_valid_o,
  output logic [DATA_W-1:0]        instr_o,
  output logic                     misalign_o,
  output logic                     range_err_o,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [DATA_W-1:0]        load_data_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   resp_addr;
  logic [ADDR_W-3:0]   resp_idx;
  logic                accept;
  logic                rd_now;
  logic                misalign_d;
  logic                range_d;
  logic                mis_q, rng_q, ok_q;
  logic                rd_en;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_data;

  assign fetch_ready_o = ((state_q == S_IDLE) || (state_q == S_RESP)) && rst_i;
  assign accept        = fetch_req_i && fetch_ready_o;

  // With zero wait states the read happens on the accept edge itself, so the
  // address must come straight from the port rather than the latch.
  assign resp_addr  = accept ? fetch_addr_i : addr_q;
  assign resp_idx   = resp_addr[ADDR_W-1:2];
  assign misalign_d = (resp_addr[1:0] != 2'b00);
  // Full-width compare: an index beyond DEPTH must not alias into the array.
  assign range_d    = (ADDR_W'(resp_idx) >= ADDR_W'(DEPTH));

  assign rd_en = rd_now && rst_i && !misalign_d && !range_d;
  assign wr_en = load_en_i && rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_now  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
            rd_now  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          rd_now  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= fetch_addr_i;
      end
      // Flags and the data-select bit only move on the edge that enters RESP.
      if (rd_now) begin
        mis_q <= misalign_d;
        rng_q <= range_d;
        ok_q  <= !(misalign_d || range_d);
      end
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (load_addr_i),
    .wr_data_i (load_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (resp_idx[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // ok_q is cleared by reset, so instr_o reads as NOP without resetting storage.
  assign instr_o       = ok_q ? rd_data : DATA_W'(NOP_WORD);
  assign misalign_o    = mis_q;
  assign range_err_o   = rng_q;
  assign fetch_valid_o = (state_q == S_RESP);

endmodule

// File: tb/tb_instr_mem_fetch_unit.sv
// tb/tb_instr_mem_fetch_unit.sv - self-checking bench for instr_mem_fetch_unit
module tb_instr_mem_fetch_unit;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_z;
  logic [31:0] addr_a, addr_z;
  logic        ready_a, valid_a, mis_a, rng_a;
  logic        ready_z, valid_z, mis_z, rng_z;
  logic [31:0] instr_a, instr_z;
  logic        load_en;
  logic [AW-1:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] model [DEPTH];
  int          loaded[$];
  int          tests  = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  instr_mem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYC(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(req_a), .fetch_addr_i(addr_a),
    .fetch_ready_o(ready_a), .fetch_valid_o(valid_a), .instr_o(instr_a),
    .misalign_o(mis_a), .range_err_o(rng_a),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  instr_mem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYC(0)) dut_z (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(req_z), .fetch_addr_i(addr_z),
    .fetch_ready_o(ready_z), .fetch_valid_o(valid_z), .instr_o(instr_z),
    .misalign_o(mis_z), .range_err_o(rng_z),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a fault of either kind yields NOP; otherwise the stored word.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) return 32'h0;
    return model[a >> 2];
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = AW'(idx);
    load_data = d;
    step();
    load_en = 1'b0;
    model[idx] = d;
    loaded.push_back(idx);
  endtask

  // Fetch on dut_a; optionally fire a load on the edge the array is read.
  task automatic fetch_a(input logic [31:0] a, input bit coll, input int cidx,
                         input logic [31:0] cdata, output int lat,
                         output logic [31:0] ins, output logic m, output logic r);
    int n = 0;
    req_a  = 1'b1;
    addr_a = a;
    while (!ready_a && n < 20) begin step(); n++; end
    step();
    req_a = 1'b0;
    chk("ready_low_after_accept", ready_a, 0);
    lat = 1;
    while (!valid_a && lat < 20) begin
      if (coll && lat == 2) begin
        load_en   = 1'b1;
        load_addr = AW'(cidx);
        load_data = cdata;
      end
      step();
      load_en = 1'b0;
      lat++;
    end
    ins = instr_a;
    m   = mis_a;
    r   = rng_a;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] a);
    int lat;
    logic [31:0] ins;
    logic m, r;
    fetch_a(a, 1'b0, 0, 32'h0, lat, ins, m, r);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_instr"}, ins, exp_word(a));
    chk({tag, "_misalign"}, m, a[1:0] != 2'b00);
    chk({tag, "_range"}, r, (a >> 2) >= 32'(DEPTH));
  endtask

  initial begin
    int lat, c, seen, idx, mode;
    logic [31:0] ins, a, d;
    logic m, r;
    logic [31:0] zaddrs [4];

    rst = 1'b0; req_a = 1'b0; addr_a = '0; req_z = 1'b0; addr_z = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    step(); step();
    chk("rst_valid", valid_a, 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_mis", mis_a, 0);
    chk("rst_rng", rng_a, 0);
    chk("rst_ready", ready_a, 0);
    rst = 1'b1;
    step();
    chk("ready_after_rst_a", ready_a, 1);
    chk("ready_after_rst_z", ready_z, 1);

    // Basic fetch and single-cycle pulse
    load(3, 32'h2002_0005);
    check_fetch("t1", 32'h0000_000C);
    chk("t1_instr_const", instr_a, 32'h2002_0005);
    step();
    chk("t1_pulse_one_cycle", valid_a, 0);
    chk("t1_instr_held", instr_a, 32'h2002_0005);

    // Back-to-back with request held high
    load(0, 32'hAAAA_0000);
    load(1, 32'hBBBB_0001);
    req_a = 1'b1; addr_a = 32'h0;
    step();
    addr_a = 32'h4;
    c = 1;
    while (!valid_a && c < 20) begin step(); c++; end
    chk("t2_first_lat", c, 3);
    chk("t2_first_instr", instr_a, 32'hAAAA_0000);
    step();
    chk("t2_gap_valid", valid_a, 0);
    chk("t2_gap_hold", instr_a, 32'hAAAA_0000);
    c = 1;
    while (!valid_a && c < 20) begin step(); c++; end
    req_a = 1'b0;
    chk("t2_spacing", c, 3);
    chk("t2_second_instr", instr_a, 32'hBBBB_0001);
    step();

    // Faults and the top-of-array boundary
    load(1023, 32'h1234_5678);
    check_fetch("t3_mis", 32'h0000_000E);
    chk("t3_mis_flag", mis_a, 1);
    check_fetch("t3_rng", 32'h0000_1000);
    chk("t3_rng_flag", rng_a, 1);
    check_fetch("t3_both", 32'h0000_1002);
    chk("t3_both_flags", {mis_a, rng_a}, 2'b11);
    check_fetch("t3_last", 32'h0000_0FFC);
    chk("t3_last_instr", instr_a, 32'h1234_5678);

    // Same-edge load/read collision returns the old word
    load(5, 32'hA5A5_0005);
    fetch_a(32'h14, 1'b1, 5, 32'hB5B5_0005, lat, ins, m, r);
    chk("t4_coll_old", ins, 32'hA5A5_0005);
    model[5] = 32'hB5B5_0005;
    check_fetch("t4_refetch", 32'h14);

    // Reset while waiting abandons the fetch; loads during reset are ignored
    check_fetch("t5_pre", 32'h0C);
    req_a = 1'b1; addr_a = 32'h14;
    step();
    req_a = 1'b0;
    rst = 1'b0;
    load_en = 1'b1; load_addr = AW'(3); load_data = 32'hDEAD_BEEF;
    step();
    load_en = 1'b0;
    chk("t5_valid", valid_a, 0);
    chk("t5_instr", instr_a, 0);
    chk("t5_flags", {mis_a, rng_a}, 2'b00);
    chk("t5_ready_in_rst", ready_a, 0);
    rst = 1'b1;
    step();
    chk("t5_ready", ready_a, 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_a) seen++;
      step();
    end
    chk("t5_no_pulse", seen, 0);
    check_fetch("t5_keep3", 32'h0C);
    check_fetch("t5_keep5", 32'h14);

    // Randomised loads, fetches and collisions against the model
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 4));
      if (mode == 0) begin
        load(int'($urandom_range(0, 63)), $urandom);
      end else begin
        idx = loaded[$urandom_range(0, loaded.size() - 1)];
        case (mode)
          1: a = 32'(idx) << 2;
          2: a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
          default: a = $urandom | 32'h0000_1000;
        endcase
        if (mode == 1 && $urandom_range(0, 1) == 1) begin
          d = $urandom;
          fetch_a(a, 1'b1, idx, d, lat, ins, m, r);
          chk("rnd_coll_instr", ins, exp_word(a));
          model[idx] = d;
        end else begin
          fetch_a(a, 1'b0, 0, 32'h0, lat, ins, m, r);
          chk("rnd_instr", ins, exp_word(a));
        end
        chk("rnd_latency", lat, 3);
        chk("rnd_misalign", m, a[1:0] != 2'b00);
        chk("rnd_range", r, (a >> 2) >= 32'(DEPTH));
      end
    end

    // Zero-wait-state instance
    load(2, 32'h0000_2222);
    req_z = 1'b1; addr_z = 32'h08;
    step();
    chk("t6_valid_next", valid_z, 1);
    chk("t6_instr", instr_z, exp_word(32'h08));
    zaddrs[0] = 32'h00; zaddrs[1] = 32'h04; zaddrs[2] = 32'h0E; zaddrs[3] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      addr_z = zaddrs[i];
      step();
      chk("t6_stream_valid", valid_z, 1);
      chk("t6_stream_instr", instr_z, exp_word(zaddrs[i]));
      chk("t6_stream_mis", mis_z, zaddrs[i][1:0] != 2'b00);
    end
    req_z = 1'b0;
    step();
    chk("t6_idle", valid_z, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
